// File: rtl/lcd_text_arbiter.sv
// lcd_text_arbiter
// Shares one LCD text sender between NUM_REQ requesters. A round-robin
// arbiter picks one owner, latches its message, fires a single start pulse
// at the sender, then waits for the sender's completion level. A per-message
// watchdog aborts a stuck sender. On completion or abort, the block pulses
// done/error back to the owner.
//
// Handshake contract, used the same way on every interface of this block:
//   - req[i] is a level. The requester raises it and holds it until it sees
//     done[i]. Dropping it early does not cancel a message that has already
//     been granted.
//   - sendText is a one-cycle start strobe. text is stable from the cycle
//     grant is raised until the next grant, so the sender may sample text
//     at any time after the strobe.
//   - sendingDone is a level owned by the sender. It may still be high from
//     the previous message when a new strobe goes out. Completion therefore
//     counts only after the level has first been seen low (ARM), followed by
//     a high (WAIT).
//   - done/error are one-cycle pulses in the COMPLETE state. error is never
//     high without done.
module lcd_text_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TEXT_LENGTH    = 34,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*8*TEXT_LENGTH-1:0] req_text,
  output logic [NUM_REQ-1:0]              done,
  output logic                            error,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            sendText,
  output logic [8*TEXT_LENGTH-1:0]        text,
  input  logic                            sendingDone,
  output logic [2:0]                      stateDbg
);

  localparam int MSG_W = 8 * TEXT_LENGTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  // Controller states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_ARM      = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_COMPLETE = 3'd4;

  logic [2:0]         state;
  logic [IDX_W-1:0]   winner;      // owner of the current message
  logic [IDX_W-1:0]   lastWinner;  // owner of the last completed message
  logic [TMR_W-1:0]   timer;       // cycles spent in ARM/WAIT this message
  logic               errFlag;     // current message ended by timeout

  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] pickOneHot;
  logic [MSG_W-1:0]   pickText;
  logic [TMR_W-1:0]   timerNext;
  logic               timeoutHit;

  // Round-robin search: first active request after the last winner, wrapping
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(lastWinner) + off) % NUM_REQ);
      if (!pickValid && req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  // Decode the chosen requester into a one-hot grant and select its message
  always_comb begin
    pickOneHot = '0;
    pickText   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickIdx == IDX_W'(i)) begin
        pickOneHot[i] = 1'b1;
        pickText      = req_text[i*MSG_W +: MSG_W];
      end
    end
  end

  // Saturating watchdog increment; the limit check looks at the next value
  // so the abort lands exactly TIMEOUT_CYCLES cycles after ARM is entered
  always_comb begin
    timerNext  = (timer == TMR_LIMIT) ? timer : (timer + TMR_ONE);
    timeoutHit = (timerNext >= TMR_LIMIT);
  end

  // Controller: arbitrate, issue, wait for the sender, report, release
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      grant      <= '0;
      winner     <= '0;
      lastWinner <= LAST_IDX;
      timer      <= '0;
      errFlag    <= 1'b0;
      text       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pickValid) begin
            state   <= ST_ISSUE;
            grant   <= pickOneHot;
            winner  <= pickIdx;
            text    <= pickText;
            timer   <= '0;
            errFlag <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // The start strobe is high for this single cycle
          state <= ST_ARM;
        end
        ST_ARM: begin
          // A high sendingDone here is left over from the previous message
          timer <= timerNext;
          if (timeoutHit) begin
            state   <= ST_COMPLETE;
            errFlag <= 1'b1;
          end else if (!sendingDone) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real completion wins over a timeout landing in the same cycle
          timer <= timerNext;
          if (sendingDone) begin
            state <= ST_COMPLETE;
          end else if (timeoutHit) begin
            state   <= ST_COMPLETE;
            errFlag <= 1'b1;
          end
        end
        ST_COMPLETE: begin
          grant      <= '0;
          lastWinner <= winner;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Strobes are decoded straight from registered state, so they are one
  // cycle wide and drop to zero as soon as reset forces IDLE
  always_comb begin
    sendText = (state == ST_ISSUE);
    done     = (state == ST_COMPLETE) ? grant : '0;
    error    = (state == ST_COMPLETE) && errFlag;
    stateDbg = state;
  end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// tb_lcd_text_arbiter
// Directed bench for lcd_text_arbiter. It uses small parameters so the
// timeout path finishes quickly. The expected grant order is queued in
// exp_q and consumed by the message task.
module tb_lcd_text_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int TEXT_LENGTH    = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int MSG_W          = 8 * TEXT_LENGTH;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_ARM      = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_COMPLETE = 3'd4;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*MSG_W-1:0]   req_text;
  logic [NUM_REQ-1:0]         done;
  logic                       error;
  logic [NUM_REQ-1:0]         grant;
  logic                       sendText;
  logic [MSG_W-1:0]           text;
  logic                       sendingDone;
  logic [2:0]                 stateDbg;

  logic [NUM_REQ-1:0]         exp_q[$];
  int                         checks = 0;
  int                         errors = 0;

  lcd_text_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TEXT_LENGTH(TEXT_LENGTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .req(req),
    .req_text(req_text),
    .done(done),
    .error(error),
    .grant(grant),
    .sendText(sendText),
    .text(text),
    .sendingDone(sendingDone),
    .stateDbg(stateDbg)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_text(input int idx, input logic [MSG_W-1:0] t);
    req_text[idx*MSG_W +: MSG_W] = t;
  endtask

  task automatic apply_reset;
    RST = 1'b1;
    req = '0;
    sendingDone = 1'b0;
    repeat (3) tick;
    RST = 1'b0;
  endtask

  // One full message: wait for strobe, hold sendingDone low for low_cycles, then high
  task automatic do_message(input int low_cycles, input logic [NUM_REQ-1:0] next_req,
                            input logic [MSG_W-1:0] exp_text);
    logic [NUM_REQ-1:0] exp_grant;
    bit seen;
    int pulses;
    exp_grant = exp_q.pop_front();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick;
      if (sendText === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL msg_strobe: got no sendText expected pulse"); end
    checks++;
    if (grant !== exp_grant) begin errors++; $display("FAIL msg_grant: got %b expected %b", grant, exp_grant); end
    checks++;
    if (text !== exp_text) begin errors++; $display("FAIL msg_text: got %h expected %h", text, exp_text); end
    pulses = 1;
    sendingDone = 1'b0;
    for (int n = 0; n < low_cycles; n++) begin
      tick;
      if (sendText === 1'b1) pulses++;
      checks++;
      if (done !== '0) begin errors++; $display("FAIL msg_early_done: got %b expected 0000", done); end
    end
    sendingDone = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick;
      if (sendText === 1'b1) pulses++;
      if (done !== '0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL msg_done_wait: got no done expected pulse"); end
    checks++;
    if (done !== exp_grant) begin errors++; $display("FAIL msg_done: got %b expected %b", done, exp_grant); end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL msg_error: got %b expected 0", error); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL msg_pulses: got %0d expected 1", pulses); end
    req = next_req;
    tick;
    checks++;
    if (grant !== '0 || done !== '0) begin
      errors++; $display("FAIL msg_release: got grant %b done %b expected 0000 0000", grant, done);
    end
  endtask

  // Outputs held at zero while reset is asserted
  task automatic test_reset;
    RST = 1'b1;
    req = '0;
    req_text = '0;
    sendingDone = 1'b0;
    repeat (2) tick;
    checks++;
    if (grant !== '0 || done !== '0 || error !== 1'b0 || sendText !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got grant %b done %b error %b sendText %b expected zeros",
                         grant, done, error, sendText);
    end
    checks++;
    if (text !== '0) begin errors++; $display("FAIL reset_text: got %h expected 0", text); end
    checks++;
    if (stateDbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", stateDbg, ST_IDLE); end
    RST = 1'b0;
    tick;
  endtask

  // Single requester, sender low for 10 cycles then high
  task automatic test_single;
    int pulses;
    set_text(0, "HELLO...");
    req = 4'b0001;
    tick;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
    checks++;
    if (sendText !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b expected 1", sendText); end
    checks++;
    if (text !== 64'("HELLO...")) begin errors++; $display("FAIL single_text: got %h expected %h", text, 64'("HELLO...")); end
    pulses = 1;
    for (int n = 0; n < 10; n++) begin
      tick;
      if (sendText === 1'b1) pulses++;
      checks++;
      if (done !== '0) begin errors++; $display("FAIL single_early_done: got %b expected 0000", done); end
    end
    checks++;
    if (stateDbg !== ST_WAIT) begin errors++; $display("FAIL single_wait_state: got %0d expected %0d", stateDbg, ST_WAIT); end
    sendingDone = 1'b1;
    tick;
    checks++;
    if (done !== 4'b0001 || error !== 1'b0) begin
      errors++; $display("FAIL single_done: got done %b error %b expected 0001 0", done, error);
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    req = '0;
    tick;
    checks++;
    if (grant !== '0 || done !== '0 || stateDbg !== ST_IDLE) begin
      errors++; $display("FAIL single_release: got grant %b done %b state %0d expected 0000 0000 0",
                         grant, done, stateDbg);
    end
    checks++;
    if (text !== 64'("HELLO...")) begin errors++; $display("FAIL single_text_hold: got %h expected %h", text, 64'("HELLO...")); end
  endtask

  // All four requesting continuously from reset, instant sender
  task automatic test_round_robin;
    apply_reset;
    set_text(0, "ROBIN_00");
    set_text(1, "ROBIN_01");
    set_text(2, "ROBIN_02");
    set_text(3, "ROBIN_03");
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    do_message(2, 4'b1111, "ROBIN_00");
    do_message(2, 4'b1111, "ROBIN_01");
    do_message(2, 4'b1111, "ROBIN_02");
    do_message(2, 4'b1111, "ROBIN_03");
    do_message(2, 4'b0000, "ROBIN_00");
  endtask

  // sendingDone still high from the last message must not complete the new one
  task automatic test_stale_done;
    bit seen;
    sendingDone = 1'b1;
    req = 4'b0100;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick;
      if (sendText === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || grant !== 4'b0100) begin
      errors++; $display("FAIL stale_grant: got grant %b strobe %0d expected 0100 1", grant, seen);
    end
    for (int n = 0; n < 6; n++) begin
      tick;
      checks++;
      if (stateDbg !== ST_ARM || done !== '0) begin
        errors++; $display("FAIL stale_hold_arm: got state %0d done %b expected %0d 0000", stateDbg, done, ST_ARM);
      end
    end
    sendingDone = 1'b0;
    tick;
    checks++;
    if (stateDbg !== ST_WAIT) begin errors++; $display("FAIL stale_to_wait: got %0d expected %0d", stateDbg, ST_WAIT); end
    sendingDone = 1'b1;
    tick;
    checks++;
    if (done !== 4'b0100 || error !== 1'b0) begin
      errors++; $display("FAIL stale_done: got done %b error %b expected 0100 0", done, error);
    end
    req = '0;
    tick;
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL stale_release: got %b expected 0000", grant); end
  endtask

  // Sender never finishes: abort exactly TIMEOUT_CYCLES after ARM entry
  task automatic test_timeout;
    bit seen;
    int n_done;
    sendingDone = 1'b0;
    set_text(3, "TIMEOUT3");
    req = 4'b1000;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick;
      if (sendText === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || grant !== 4'b1000) begin
      errors++; $display("FAIL timeout_grant: got grant %b strobe %0d expected 1000 1", grant, seen);
    end
    n_done = 0;
    for (int n = 1; n <= 200 && n_done == 0; n++) begin
      tick;
      if (done !== '0) n_done = n;
    end
    // ARM is entered one tick after the strobe, completion 100 cycles later
    checks++;
    if (n_done !== TIMEOUT_CYCLES + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d expected %0d", n_done, TIMEOUT_CYCLES + 1);
    end
    checks++;
    if (done !== 4'b1000 || error !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: got done %b error %b expected 1000 1", done, error);
    end
    req = '0;
    tick;
    checks++;
    if (grant !== '0 || error !== 1'b0 || done !== '0) begin
      errors++; $display("FAIL timeout_release: got grant %b error %b done %b expected 0000 0 0000",
                         grant, error, done);
    end
  endtask

  // Owner's text changes and req drops mid-message; another req becomes pending
  task automatic test_text_hold;
    bit seen;
    set_text(0, "KEEPTEXT");
    set_text(2, "PENDING2");
    sendingDone = 1'b0;
    req = 4'b0001;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick;
      if (sendText === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || grant !== 4'b0001 || text !== 64'("KEEPTEXT")) begin
      errors++; $display("FAIL hold_grant: got grant %b text %h expected 0001 %h", grant, text, 64'("KEEPTEXT"));
    end
    tick;
    tick;
    checks++;
    if (stateDbg !== ST_WAIT) begin errors++; $display("FAIL hold_wait_state: got %0d expected %0d", stateDbg, ST_WAIT); end
    set_text(0, "CHANGED!");
    req = 4'b0100;
    repeat (5) tick;
    checks++;
    if (text !== 64'("KEEPTEXT")) begin errors++; $display("FAIL hold_text: got %h expected %h", text, 64'("KEEPTEXT")); end
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL hold_owner: got %b expected 0001", grant); end
    sendingDone = 1'b1;
    tick;
    checks++;
    if (done !== 4'b0001) begin errors++; $display("FAIL hold_dropped_done: got %b expected 0001", done); end
    tick;
    checks++;
    if (grant !== '0 || text !== 64'("KEEPTEXT")) begin
      errors++; $display("FAIL hold_after_release: got grant %b text %h expected 0000 %h", grant, text, 64'("KEEPTEXT"));
    end
    exp_q.push_back(4'b0100);
    do_message(2, 4'b0000, "PENDING2");
  endtask

  // Reset mid-message aborts at once; afterwards requester 0 has priority again
  task automatic test_reset_mid;
    exp_q.push_back(4'b0001);
    req = 4'b0001;
    do_message(2, 4'b0000, "CHANGED!");
    sendingDone = 1'b0;
    set_text(1, "RESETME!");
    req = 4'b0010;
    tick;
    tick;
    tick;
    checks++;
    if (stateDbg !== ST_WAIT || grant !== 4'b0010) begin
      errors++; $display("FAIL rstmid_setup: got state %0d grant %b expected %0d 0010", stateDbg, grant, ST_WAIT);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || done !== '0 || error !== 1'b0 || sendText !== 1'b0 || text !== '0) begin
      errors++; $display("FAIL rstmid_async: got grant %b done %b error %b sendText %b text %h expected zeros",
                         grant, done, error, sendText, text);
    end
    checks++;
    if (stateDbg !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", stateDbg, ST_IDLE); end
    repeat (2) begin
      tick;
      checks++;
      if (done !== '0 || grant !== '0) begin
        errors++; $display("FAIL rstmid_held: got done %b grant %b expected 0000 0000", done, grant);
      end
    end
    req = 4'b0011;
    RST = 1'b0;
    tick;
    checks++;
    if (grant !== 4'b0001 || sendText !== 1'b1) begin
      errors++; $display("FAIL rstmid_priority: got grant %b sendText %b expected 0001 1", grant, sendText);
    end
    checks++;
    if (text !== 64'("CHANGED!")) begin errors++; $display("FAIL rstmid_text: got %h expected %h", text, 64'("CHANGED!")); end
    tick;
    tick;
    sendingDone = 1'b1;
    tick;
    checks++;
    if (done !== 4'b0001 || error !== 1'b0) begin
      errors++; $display("FAIL rstmid_done: got done %b error %b expected 0001 0", done, error);
    end
    req = '0;
    tick;
  endtask

  // sequence and final report
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_stale_done;
    test_timeout;
    test_text_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_arbiter.md
LCD_TEXT_ARBITER -- requirements
Module: lcd_text_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TEXT_LENGTH, default 34, characters per message, packed 8 bits each.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000000, cycles allowed per message before abort (1 s at 50 MHz).
REQ-004 Port CLK  input  1  single clock; all state on its rising edge.
REQ-005 Port RST  input  1  reset, asynchronous, active-high.
REQ-006 Port req  input  NUM_REQ  level request per requester; held until that requester's done pulse.
REQ-007 Port req_text  input  NUM_REQ*8*TEXT_LENGTH  message per requester; requester i occupies slice i.
REQ-008 Port done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 Port error  output  1  one-cycle pulse, coincident with done, when the message timed out.
REQ-010 Port grant  output  NUM_REQ  one-hot owner of the LCD; all zero when idle.
REQ-011 Port sendText  output  1  one-cycle start pulse to the LCD text sender.
REQ-012 Port text  output  8*TEXT_LENGTH  registered message to the LCD text sender.
REQ-013 Port sendingDone  input  1  level from the LCD text sender; high after the last nibble, cleared by the sender's first command of the next message.

Function
REQ-014 State machine SHALL have states IDLE, ISSUE, ARM, WAIT, COMPLETE.
REQ-015 In IDLE with any req bit high, the block SHALL pick a winner round-robin, starting at (last winner + 1) mod NUM_REQ, and enter ISSUE next cycle.
REQ-016 On the IDLE->ISSUE transition, grant SHALL become one-hot on the winner, and text SHALL latch that requester's req_text slice.
REQ-017 text SHALL stay constant from the latch until the next grant; changes on req_text during a message SHALL be ignored.
REQ-018 In ISSUE, sendText SHALL be high for exactly one cycle, then the state SHALL move to ARM.
REQ-019 ARM SHALL wait for sendingDone low, then enter WAIT; this stops a stale high level from the previous message from being taken as completion.
REQ-020 WAIT SHALL treat sendingDone high as completion and enter COMPLETE.
REQ-021 A timeout counter SHALL clear on entry to ISSUE and increment each cycle in ARM and WAIT.
REQ-022 When the timeout counter reaches TIMEOUT_CYCLES in ARM or WAIT, the block SHALL enter COMPLETE with error flagged; the counter SHALL saturate and never wrap.
REQ-023 In COMPLETE, done[winner] SHALL pulse for one cycle and error SHALL pulse in the same cycle if flagged.
REQ-024 In the cycle after COMPLETE, grant SHALL clear, the winner SHALL be recorded as last winner, and the state SHALL return to IDLE.
REQ-025 The earliest re-arbitration SHALL be one cycle after return to IDLE; the minimum gap between successive sendText pulses is therefore bounded by message time plus 4 cycles.
REQ-026 If the granted requester drops req mid-message, the message SHALL still complete and done SHALL still pulse; messages are not cancelled.
REQ-027 A req rising during a message SHALL be held pending and arbitrated at the next IDLE.
REQ-028 When several requesters rise in the same cycle, the round-robin order SHALL select exactly one.
REQ-029 At most one sendText pulse SHALL be issued per grant.

Reset
REQ-030 While RST is high, the state SHALL be IDLE and grant, done, error, sendText, the timeout counter and text SHALL all be 0; last winner SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-031 RST asserted mid-message SHALL abort immediately with no done pulse; after deassertion the block SHALL behave as if freshly powered up.

Verification
REQ-032 Scenario: after reset, req=0001 with text0="HELLO..." -> grant=0001 one cycle later; sendText pulses once; text=text0; sendingDone model low 10 cycles then high -> done=0001 pulse, error=0.
REQ-033 Scenario: req=1111 held continuously, instant sender -> grants in order 0001, 0010, 0100, 1000, 0001; each done pulses once.
REQ-034 Scenario: sendingDone stuck high from the previous message, new grant issued -> block stays in ARM until sendingDone falls; no early done.
REQ-035 Scenario: TIMEOUT_CYCLES=100, sendingDone never rises -> done and error pulse together 100 cycles after ARM entry; grant clears the next cycle.
REQ-036 Scenario: req_text of the owner changed while in WAIT -> text output unchanged; req dropped mid-message -> done still pulses.
REQ-037 Scenario: RST asserted in WAIT -> all outputs 0 asynchronously; with req=0011 after release -> grant=0001 first.
